// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - exception/mret sequencer feeding the machine-mode CSR file and fetch redirect
// Optional feature macro: TRAP_MTVAL_EN (mtval next-value generation; mtval_d_o is 0 when undefined).
module trap_ctrl #(
  parameter logic [1:0]  MPP_VALUE = 2'b11,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic        exc_inst_misalign_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ecall_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_load_misalign_i,
  input  logic        exc_store_misalign_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_addr_i,
  input  logic [31:0] exc_instr_i,
  input  logic        mret_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mcause_i,
  input  logic        redirect_ready_i,
  output logic        we_exc_o,
  output logic [31:0] mcause_d_o,
  output logic [31:0] mepc_d_o,
  output logic [31:0] mtval_d_o,
  output logic [31:0] mstatus_d_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] target_q, target_d;
  logic [31:0] rpc_q, rpc_d;

  logic        exc_any, take;
  logic [31:0] trap_cause, trap_tval, trap_mstatus, ret_mstatus;

  assign exc_any = exc_inst_misalign_i | exc_illegal_i | exc_ecall_i | exc_ebreak_i |
                   exc_load_misalign_i | exc_store_misalign_i;
  assign take    = (state_q == IDLE) && exc_valid_i && (exc_any || mret_i);

  // Priority order differs from numeric cause order: ecall outranks ebreak.
  always_comb begin
    trap_cause = 32'd0;
    trap_tval  = 32'd0;
    if (exc_inst_misalign_i) begin
      trap_cause = 32'd0;
      trap_tval  = exc_addr_i;
    end else if (exc_illegal_i) begin
      trap_cause = 32'd2;
      trap_tval  = exc_instr_i;
    end else if (exc_ecall_i) begin
      trap_cause = 32'd11;
    end else if (exc_ebreak_i) begin
      trap_cause = 32'd3;
    end else if (exc_load_misalign_i) begin
      trap_cause = 32'd4;
      trap_tval  = exc_addr_i;
    end else if (exc_store_misalign_i) begin
      trap_cause = 32'd6;
      trap_tval  = exc_addr_i;
    end
  end

  always_comb begin
    trap_mstatus        = mstatus_i;
    trap_mstatus[7]     = mstatus_i[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = MPP_VALUE;
    ret_mstatus         = mstatus_i;
    ret_mstatus[3]      = mstatus_i[7];
    ret_mstatus[7]      = 1'b1;
    ret_mstatus[12:11]  = MPP_VALUE;
  end

  always_comb begin
    mcause_d  = mcause_q;
    mepc_d    = mepc_q;
    mstatus_d = mstatus_q;
    target_d  = target_q;
    rpc_d     = rpc_q;
    if (take) begin
      if (exc_any) begin
        mcause_d  = trap_cause;
        mepc_d    = exc_pc_i & 32'hFFFF_FFFC;
        mstatus_d = trap_mstatus;
        target_d  = mtvec_i & 32'hFFFF_FFFC;
      end else begin
        mcause_d  = mcause_i;
        mepc_d    = mepc_i;
        mstatus_d = ret_mstatus;
        target_d  = mepc_i & 32'hFFFF_FFFC;
      end
    end
    if (state_q == COMMIT) rpc_d = target_q;
  end

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_q, mtval_d;

  always_comb begin
    mtval_d = mtval_q;
    if (take) mtval_d = exc_any ? trap_tval : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) mtval_q <= 32'd0;
    else        mtval_q <= mtval_d;
  end

  assign mtval_d_o = mtval_q;
`else
  logic unused_tval;
  assign unused_tval = ^trap_tval;
  assign mtval_d_o   = 32'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcause_q  <= 32'd0;
      mepc_q    <= 32'd0;
      mstatus_q <= 32'd0;
      target_q  <= 32'd0;
      rpc_q     <= RESET_PC;
    end else begin
      mcause_q  <= mcause_d;
      mepc_q    <= mepc_d;
      mstatus_q <= mstatus_d;
      target_q  <= target_d;
      rpc_q     <= rpc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    we_exc_o         = (state_q == COMMIT);
    flush_o          = (state_q == COMMIT) || (state_q == REDIRECT);
    busy_o           = (state_q != IDLE);
    redirect_valid_o = (state_q == REDIRECT);
  end

  assign mcause_d_o    = mcause_q;
  assign mepc_d_o      = mepc_q;
  assign mstatus_d_o   = mstatus_q;
  assign redirect_pc_o = rpc_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Exception/return sequencer that sits directly upstream of the machine-mode CSR file.
- Collects synchronous exception flags and mret from the execute/writeback stage and picks the highest-priority cause.
- Produces the mcause/mepc/mtval/mstatus next-values together with the exception write strobe for the CSR file.
- Flushes the pipeline, then issues a PC redirect to the mtvec base (trap) or to mepc (mret) through a valid/ready handshake with fetch.

Parameters:
- MPP_VALUE, 2'b11, value written to mstatus.MPP on trap and restored on mret (machine-only core).
- RESET_PC, 32'h0000_0000, value of redirect_pc_o while idle and after reset.

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- exc_valid_i  in  1  instruction at commit point is valid; exception flags are qualified by it
- exc_inst_misalign_i  in  1  instruction address misaligned
- exc_illegal_i  in  1  illegal instruction
- exc_ecall_i  in  1  ecall
- exc_ebreak_i  in  1  ebreak
- exc_load_misalign_i  in  1  load address misaligned
- exc_store_misalign_i  in  1  store address misaligned
- exc_pc_i  in  32  PC of the committing instruction
- exc_addr_i  in  32  faulting data/target address
- exc_instr_i  in  32  instruction word
- mret_i  in  1  mret committing; qualified by exc_valid_i
- mstatus_i  in  32  current mstatus from the CSR file
- mtvec_i  in  32  current mtvec from the CSR file
- mepc_i  in  32  current mepc from the CSR file
- mcause_i  in  32  current mcause from the CSR file
- redirect_ready_i  in  1  fetch accepts redirect
- we_exc_o  out  1  exception write strobe to the CSR file
- mcause_d_o  out  32  mcause next-value
- mepc_d_o  out  32  mepc next-value
- mtval_d_o  out  32  mtval next-value
- mstatus_d_o  out  32  mstatus next-value
- flush_o  out  1  kill all younger instructions
- busy_o  out  1  block is not idle
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target

Behaviour:
- FSM states: IDLE, COMMIT, REDIRECT.
- Reset (rst_i==0 at a clock edge), including mid-sequence:
  - state goes to IDLE.
  - we_exc_o, flush_o, busy_o, redirect_valid_o = 0.
  - All *_d_o = 0.
  - redirect_pc_o = RESET_PC.
  - No partial write or redirect is ever emitted after reset.
- IDLE:
  - If exc_valid_i and any exception flag is set: latch cause, pc, tval and the computed mstatus; next state COMMIT.
  - Else if exc_valid_i && mret_i: latch the return values; next state COMMIT.
  - Otherwise stay in IDLE.
- Exception priority (highest first), with mcause code: inst_misalign=0, illegal=2, ecall=11, ebreak=3, load_misalign=4, store_misalign=6.
  - mcause bit31 = 0 (no interrupts).
  - An exception beats a simultaneous mret; the mret is discarded.
- Trap values:
  - mepc_d = exc_pc_i with bits [1:0] forced to 0.
  - mtval_d: exc_addr_i for the three misaligned causes; exc_instr_i for illegal; 0 for ecall/ebreak.
  - mstatus_d = mstatus_i with MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP[12:11] <= MPP_VALUE; all other bits unchanged.
  - Target = {mtvec_i[31:2], 2'b00}, regardless of mode bits.
- mret values:
  - mcause_d = mcause_i, mepc_d = mepc_i, mtval_d = 0.
  - mstatus_d: MIE <= MPIE, MPIE <= 1, MPP <= MPP_VALUE.
  - Target = {mepc_i[31:2], 2'b00}.
- Latching rule: all values are captured at the IDLE->COMMIT edge. Later changes on the inputs do not affect them.
- COMMIT (exactly 1 cycle):
  - we_exc_o=1 with the latched *_d_o values.
  - flush_o=1, busy_o=1.
  - Next state REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, redirect_pc_o=target, flush_o=1, busy_o=1.
  - Hold valid and target stable until redirect_ready_i=1; on that edge go to IDLE.
  - If ready is already 1 in the first REDIRECT cycle, the return to IDLE happens on that cycle's edge.
- Exception and mret inputs arriving in COMMIT or REDIRECT are ignored (the instructions are flushed).
- Latency: exception sampled at edge N; we_exc_o high in cycle N+1; redirect_valid_o first high in N+2.
- Outside COMMIT: we_exc_o=0 and *_d_o hold their last latched values. In IDLE, redirect_pc_o holds its last value (RESET_PC after reset).
- Back-to-back: a new exception is accepted in the first IDLE cycle after the handshake completes.

Optional Feature:
- TRAP_MTVAL_EN defined: mtval_d_o is produced as described above.
- TRAP_MTVAL_EN undefined: mtval_d_o is constant 0, and the exc_addr_i/exc_instr_i latches are removed.

Test Plan:
- Illegal trap:
  - Stimulus: reset, then exc_valid_i=1, exc_illegal_i=1, exc_pc_i=32'h100, exc_instr_i=32'hFFFF_FFFF, mtvec_i=32'h801, mstatus_i=32'h8.
  - Required: cycle+1 we_exc_o=1, mcause_d=2, mepc_d=32'h100, mtval_d=32'hFFFF_FFFF, mstatus_d=32'h1880. Cycle+2 redirect_valid_o=1, redirect_pc_o=32'h800.
- Priority:
  - Stimulus: exc_ecall_i=1 and exc_load_misalign_i=1 together, exc_addr_i=32'h13.
  - Required: mcause_d=11, mtval_d=0.
- mret:
  - Stimulus: mret_i=1, mstatus_i=32'h1880, mepc_i=32'h203.
  - Required: mstatus_d=32'h1888, redirect_pc_o=32'h200.
- Handshake stall:
  - Stimulus: redirect_ready_i=0 for 4 cycles, and an exc_illegal_i pulse during that wait.
  - Required: redirect_valid_o and redirect_pc_o stay stable; no second we_exc_o; return to IDLE one edge after ready=1.
- Reset mid-sequence:
  - Stimulus: rst_i=0 asserted in the COMMIT cycle.
  - Required: next cycle all outputs 0, redirect_pc_o=RESET_PC, and no redirect is issued after rst_i returns to 1.
- Store misalign:
  - Stimulus: exc_store_misalign_i=1, exc_addr_i=32'h1002, in two builds (with and without TRAP_MTVAL_EN).
  - Required: mcause_d=6; mtval_d=32'h1002 with TRAP_MTVAL_EN defined, 0 without.
